arm7ff_sp_macro_model: RTL
==========================

# arm7ff_sp_macro_model

- Cycle-level RTL responder model of the ARM7FF single-port RF/SRAM macro pin interface: active-low CEN/GWEN/WEN, EMA trims, RET/QNAP power pins.
- Instantiated in place of a missing hard macro behind the single-port RAM wrapper, for simulation and FPGA builds.
- Adds power-mode sequencing (quick-nap, retention, wake-up delay), a READY status and a sticky protocol-violation flag, so initiator-side power management can be verified.

## Interface
- ADDR_WIDTH, 7, address bits; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 64, word width in bits
- WAKE_CYCLES, 2, wake-up delay after leaving NAP/RET; legal range 0..15
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- A  in  ADDR_WIDTH  word address
- D  in  DATA_WIDTH  write data
- CEN  in  1  chip enable, active-low
- GWEN  in  1  global write enable, active-low (0 = write, 1 = read)
- WEN  in  DATA_WIDTH  per-bit write enable, active-low, WEN[0] = LSB
- Q  out  DATA_WIDTH  read data
- EMA  in  3  read margin trim; functionally ignored
- EMAW  in  2  write margin trim; functionally ignored
- EMAS  in  1  sense margin trim; functionally ignored
- STOV  in  1  self-timed override; functionally ignored
- RET  in  1  retention request, active-high
- QNAP  in  1  quick-nap request, active-high
- READY  out  1  1 when state is ACTIVE (model-only pin)
- ERR  out  1  sticky violation flag; cleared only by RST (model-only pin)

## Operation
- States: INIT (only with the macro below), ACTIVE, NAP, RETN, WAKE. 4-bit wake counter.
- ACTIVE, CEN=0, GWEN=0: mem[A] <= (mem[A] & WEN) | (D & ~WEN). Q holds.
- ACTIVE, CEN=0, GWEN=1: Q <= mem[A].
- ACTIVE, CEN=1: no access; Q holds.
- Low-power entry only at an edge with CEN=1:
  - RET=1 -> RETN; RET has priority over QNAP.
  - else QNAP=1 -> NAP.
  - RET/QNAP sampled with CEN=0 in ACTIVE: the access completes normally, entry is deferred, no ERR.
- NAP/RETN: memory retained; Q = 0. Exit at the edge where the controlling request is sampled low.
  - RETN exits when RET=0. If QNAP=1 at that edge, go to NAP.
  - NAP exits when QNAP=0.
  - On exit: WAKE with counter = WAKE_CYCLES-1; if WAKE_CYCLES=0, go straight to ACTIVE.
- WAKE: Q = 0. Counter decrements each edge; at the edge where it reads 0, go to ACTIVE.
  - RET or QNAP sampled high during WAKE -> back to RETN/NAP with the same priority; counter discarded.
- Violation: CEN=0 sampled in any state other than ACTIVE.
  - Access ignored (no write, Q unchanged); ERR <= 1.
- EMA/EMAW/EMAS/STOV never affect data or timing.

## Timing
- Read latency is 1 cycle: A sampled at edge N, Q valid after edge N. Q is stable until the next read or a state change.
- Write takes effect at edge N. A read of the same address at edge N+1 returns the new data.
- Request dropped at edge N: state is ACTIVE and READY=1 after edge N+WAKE_CYCLES. First accepted access is sampled at edge N+WAKE_CYCLES+1.
- READY and ERR are registered, no combinational paths.
- Reset: state -> ACTIVE (INIT with macro); Q=0, READY=1 (0 with macro), ERR=0, counters=0.
  - Memory contents are untouched without the macro.
  - Reset during WAKE/NAP/RETN aborts to the reset state within the same edge.

## Configuration
- SP_RAM_MODEL_INIT_CLEAR_EN defined:
  - Reset enters INIT. An address counter writes zero to words 0..DEPTH-1, one per cycle.
  - After the last word the model goes to ACTIVE: READY rises after edge R+DEPTH, where R is the last RST-high edge.
  - CEN=0 during INIT is a violation: access ignored, ERR <= 1. RET/QNAP are ignored during INIT.
- Undefined:
  - No INIT state; contents are X until written; READY=1 right after reset.

## Test plan
- Write/read with byte mask: ADDR_WIDTH=7, DATA_WIDTH=64.
  - Write 0x1122334455667788 to A=5 with WEN=0, then D=0xFFFF_FFFF_FFFF_FFFF with WEN=0xFFFF_FFFF_FFFF_FF00.
  - Read A=5 -> Q=0x11223344556677FF one cycle later.
- Nap/wake, WAKE_CYCLES=2: QNAP=1 with CEN=1 -> READY=0, Q=0. Drop QNAP at edge N -> READY=1 after edge N+2.
  - Read sampled at N+1 -> ignored, ERR=1. Read sampled at N+3 returns pre-nap data.
- Retention priority: RET=1 and QNAP=1 together -> RETN. Drop RET with QNAP=1 -> NAP, READY stays 0. Memory contents preserved.
- Deferred entry: QNAP=1 with CEN=0, GWEN=1, A=9 -> Q=mem[9], READY stays 1. Next edge with CEN=1 -> NAP.
- Reset mid-WAKE: assert RST while in WAKE -> next cycle READY=1, ERR=0, Q=0. Contents intact when the macro is undefined.
- Init clear, macro defined, DEPTH=128: after reset, READY rises after edge R+128 and every address reads 0. CEN=0 during INIT -> ERR=1.

Source files
------------

// File: rtl/arm7ff_sp_macro_model_if.sv
// Pin bundle of the ARM7FF single-port RF/SRAM macro model.
// The master side is the RAM wrapper (initiator); the slave side is the macro model.
interface arm7ff_sp_macro_model_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] D;
    logic                  CEN;
    logic                  GWEN;
    logic [DATA_WIDTH-1:0] WEN;
    logic [DATA_WIDTH-1:0] Q;
    logic [2:0]            EMA;
    logic [1:0]            EMAW;
    logic                  EMAS;
    logic                  STOV;
    logic                  RET;
    logic                  QNAP;
    logic                  READY;
    logic                  ERR;

    modport master (
        output A, D, CEN, GWEN, WEN, EMA, EMAW, EMAS, STOV, RET, QNAP,
        input  Q, READY, ERR
    );

    modport slave (
        input  A, D, CEN, GWEN, WEN, EMA, EMAW, EMAS, STOV, RET, QNAP,
        output Q, READY, ERR
    );
endinterface

// File: rtl/arm7ff_sp_macro_model.sv
// Cycle-level responder model of the ARM7FF single-port RF/SRAM macro.
// Models read/masked-write, quick-nap / retention power modes with a wake-up
// delay, a READY status and a sticky protocol-violation flag (ERR).
// Optional feature: define SP_RAM_MODEL_INIT_CLEAR_EN to add an INIT state
// that zero-fills the whole array after every reset before going ACTIVE.
module arm7ff_sp_macro_model #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 64,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    arm7ff_sp_macro_model_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAKE_LOAD = (WAKE_CYCLES == 0) ? 4'd0 : 4'(WAKE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_NAP    = 3'd2,
        ST_RETN   = 3'd3,
        ST_WAKE   = 3'd4
    } state_t;

`ifdef SP_RAM_MODEL_INIT_CLEAR_EN
    localparam state_t RESET_STATE = ST_INIT;
    localparam logic   RESET_READY = 1'b0;
`else
    localparam state_t RESET_STATE = ST_ACTIVE;
    localparam logic   RESET_READY = 1'b1;
`endif

    // Bit-masked write merge: WEN bit low selects the new data bit.
    function automatic logic [DATA_WIDTH-1:0] merge_write(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [DATA_WIDTH-1:0] wen_n
    );
        return (old_word & wen_n) | (new_word & ~wen_n);
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [3:0]            wake_cnt_r;
    logic [3:0]            wake_cnt_next_s;
    logic [DATA_WIDTH-1:0] q_r;
    logic                  ready_r;
    logic                  err_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  access_ok_s;
    logic                  violation_s;
    logic                  low_power_next_s;
    logic                  unused_trim_s;

    // Margin trims and self-timed override have no functional effect.
    assign unused_trim_s = ^{bus.EMA, bus.EMAW, bus.EMAS, bus.STOV};

    assign access_ok_s      = (state_r == ST_ACTIVE) && !bus.CEN;
    assign violation_s      = (state_r != ST_ACTIVE) && !bus.CEN;
    assign low_power_next_s = (state_next_s == ST_NAP) || (state_next_s == ST_RETN) ||
                              (state_next_s == ST_WAKE);

    assign bus.Q     = q_r;
    assign bus.READY = ready_r;
    assign bus.ERR   = err_r;

`ifdef SP_RAM_MODEL_INIT_CLEAR_EN
    logic [ADDR_WIDTH-1:0] init_addr_r;

    // Zero-fill address counter, walks the array once per reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            init_addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (state_r == ST_INIT) begin
            init_addr_r <= init_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end
`endif

    // Power-mode sequencing: entry only when idle, RET beats QNAP, wake delay.
    always_comb begin
        state_next_s    = state_r;
        wake_cnt_next_s = wake_cnt_r;
        case (state_r)
            ST_ACTIVE: begin
                if (bus.CEN && bus.RET) begin
                    state_next_s = ST_RETN;
                end else if (bus.CEN && bus.QNAP) begin
                    state_next_s = ST_NAP;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            ST_RETN: begin
                if (bus.RET) begin
                    state_next_s = ST_RETN;
                end else if (bus.QNAP) begin
                    state_next_s = ST_NAP;
                end else begin
                    state_next_s    = (WAKE_CYCLES == 0) ? ST_ACTIVE : ST_WAKE;
                    wake_cnt_next_s = WAKE_LOAD;
                end
            end
            ST_NAP: begin
                if (bus.QNAP) begin
                    state_next_s = ST_NAP;
                end else begin
                    state_next_s    = (WAKE_CYCLES == 0) ? ST_ACTIVE : ST_WAKE;
                    wake_cnt_next_s = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (bus.RET) begin
                    state_next_s    = ST_RETN;
                    wake_cnt_next_s = 4'd0;
                end else if (bus.QNAP) begin
                    state_next_s    = ST_NAP;
                    wake_cnt_next_s = 4'd0;
                end else if (wake_cnt_r == 4'd0) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    wake_cnt_next_s = wake_cnt_r - 4'd1;
                end
            end
            ST_INIT: begin
`ifdef SP_RAM_MODEL_INIT_CLEAR_EN
                if (&init_addr_r) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    state_next_s = ST_INIT;
                end
`else
                state_next_s = ST_ACTIVE;
`endif
            end
            default: begin
                state_next_s    = ST_ACTIVE;
                wake_cnt_next_s = 4'd0;
            end
        endcase
    end

    // State, wake counter and registered status/read-data outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= RESET_STATE;
            wake_cnt_r <= 4'd0;
            ready_r    <= RESET_READY;
            err_r      <= 1'b0;
            q_r        <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r    <= state_next_s;
            wake_cnt_r <= wake_cnt_next_s;
            ready_r    <= (state_next_s == ST_ACTIVE);
            err_r      <= err_r | violation_s;
            if (low_power_next_s) begin
                q_r <= {DATA_WIDTH{1'b0}};
            end else if (access_ok_s && bus.GWEN) begin
                q_r <= mem_r[bus.A];
            end
        end
    end

    // Storage array: not reset; written by accepted writes (or by zero-fill).
    always_ff @(posedge CLK) begin
        if (!RST) begin
`ifdef SP_RAM_MODEL_INIT_CLEAR_EN
            if (state_r == ST_INIT) begin
                mem_r[init_addr_r] <= {DATA_WIDTH{1'b0}};
            end else if (access_ok_s && !bus.GWEN) begin
                mem_r[bus.A] <= merge_write(mem_r[bus.A], bus.D, bus.WEN);
            end
`else
            if (access_ok_s && !bus.GWEN) begin
                mem_r[bus.A] <= merge_write(mem_r[bus.A], bus.D, bus.WEN);
            end
`endif
        end
    end
endmodule
